seg7_scan_mux: RTL and testbench

- Time-multiplexed 7-segment display driver; sits directly downstream of the binary-to-BCD/7-seg decoder stage.
- Takes the three decoded digit patterns (units, tens, hundreds) and drives one shared active-low segment bus plus per-digit active-low anode enables.
- Scans digits round-robin, with an all-off guard interval between digits to suppress ghosting.
- Takes a coherent snapshot of all three inputs once per scan frame, so a value never tears mid-frame.

---
 rtl/seg7_scan_mux.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Round-robin 3-digit 7-segment scan driver with blank guard slots and per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_mux #(
  parameter int SHOW_CYC  = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [6:0] uni_i,
  input  logic [6:0] dec_i,
  input  logic [6:0] cen_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       frame_o
);

  localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [6:0]    SEG_DARK   = 7'h7F;
  localparam logic [6:0]    SEG_ZERO   = 7'b0000001;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_digit;
  logic [CW-1:0] r_cnt;
  logic          r_init;
  logic [6:0]    r_snap_u;
  logic [6:0]    r_snap_t;
  logic [6:0]    r_snap_h;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_frame;

  state_t        w_state_nx;
  logic [1:0]    w_digit_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_snap_ld;
  logic [6:0]    w_seg_nx;
  logic [3:0]    w_an_nx;

  // Pattern to drive for digit d, with leading-zero blanking applied when built in.
  function automatic logic [6:0] f_digit_seg(
    input logic [1:0] d,
    input logic [6:0] u,
    input logic [6:0] t,
    input logic [6:0] h
  );
    logic h_blank;
    logic t_blank;
`ifdef SEG7_SCAN_LZB_EN
    h_blank = (h == SEG_ZERO);
    t_blank = h_blank && (t == SEG_ZERO);
`else
    h_blank = 1'b0;
    t_blank = 1'b0;
`endif
    case (d)
      2'd0:    f_digit_seg = u;
      2'd1:    f_digit_seg = t_blank ? SEG_DARK : t;
      2'd2:    f_digit_seg = h_blank ? SEG_DARK : h;
      default: f_digit_seg = SEG_DARK;
    endcase
  endfunction

  // Next-state logic; enable loss beats everything, then restart after reset or OFF.
  always_comb begin
    w_state_nx = r_state;
    w_digit_nx = r_digit;
    w_cnt_nx   = r_cnt;
    w_snap_ld  = 1'b0;
    if (!en_i) begin
      w_state_nx = ST_OFF;
      w_digit_nx = 2'd0;
      w_cnt_nx   = '0;
    end else if (r_init || (r_state == ST_OFF)) begin
      w_state_nx = ST_BLANK;
      w_digit_nx = 2'd0;
      w_cnt_nx   = '0;
      w_snap_ld  = 1'b1;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nx = ST_SHOW;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_nx = ST_BLANK;
            w_cnt_nx   = '0;
            w_digit_nx = (r_digit == 2'd2) ? 2'd0 : (r_digit + 2'd1);
            w_snap_ld  = (r_digit == 2'd2);
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nx = ST_OFF;
          w_digit_nx = 2'd0;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next state so the registered pins carry no extra lag.
  always_comb begin
    w_an_nx  = 4'hF;
    w_seg_nx = SEG_DARK;
    if (w_state_nx == ST_SHOW) begin
      w_an_nx  = ~(4'b0001 << w_digit_nx);
      w_seg_nx = f_digit_seg(w_digit_nx, r_snap_u, r_snap_t, r_snap_h);
    end else begin
      w_an_nx  = 4'hF;
      w_seg_nx = SEG_DARK;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_BLANK;
      r_digit  <= 2'd0;
      r_cnt    <= '0;
      r_init   <= 1'b1;
      r_snap_u <= SEG_DARK;
      r_snap_t <= SEG_DARK;
      r_snap_h <= SEG_DARK;
      r_seg    <= SEG_DARK;
      r_an     <= 4'hF;
      r_frame  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_digit <= w_digit_nx;
      r_cnt   <= w_cnt_nx;
      r_init  <= 1'b0;
      if (w_snap_ld) begin
        r_snap_u <= uni_i;
        r_snap_t <= dec_i;
        r_snap_h <= cen_i;
      end
      r_seg   <= w_seg_nx;
      r_an    <= w_an_nx;
      r_frame <= w_snap_ld;
    end
  end

  assign seg_o   = r_seg;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with SHOW_CYC=4, BLANK_CYC=2 (frame = 18 cycles).
module tb_seg7_scan_mux;

  logic       clk;
  logic       rst;
  logic       en;
  logic [6:0] uni;
  logic [6:0] dec;
  logic [6:0] cen;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] U1   = 7'b1001111;
  localparam logic [6:0] D1   = 7'b0010010;
  localparam logic [6:0] C1   = 7'b0000110;
  localparam logic [6:0] U2   = 7'b0100100;
  localparam logic [6:0] U3   = 7'b1001100;
  localparam logic [6:0] D3   = 7'b0000000;
  localparam logic [6:0] ZERO = 7'b0000001;
  localparam logic [6:0] DARK = 7'h7F;

  seg7_scan_mux #(.SHOW_CYC(4), .BLANK_CYC(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .uni_i   (uni),
    .dec_i   (dec),
    .cen_i   (cen),
    .seg_o   (seg),
    .an_o    (an),
    .frame_o (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'(DARK));
    chk({tag, "_frame"}, 32'(frame), 32'd0);
  endtask

  // k = cycle within frame; each slot is 2 blank cycles then 4 lit cycles.
  task automatic chk_cycle(input int k, input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
    int slot;
    int off;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    slot = k / 6;
    off  = k % 6;
    if (off < 2) begin
      exp_an  = 4'hF;
      exp_seg = DARK;
    end else begin
      exp_an  = ~(4'b0001 << slot);
      exp_seg = (slot == 0) ? u : ((slot == 1) ? t : h);
    end
    chk($sformatf("an_k%0d", k), 32'(an), 32'(exp_an));
    chk($sformatf("seg_k%0d", k), 32'(seg), 32'(exp_seg));
    chk($sformatf("frame_k%0d", k), 32'(frame), (k == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    uni = U1;
    dec = D1;
    cen = C1;
    step();
    step();
    chk_dark("reset");

    // Scenario 1 + 2: first frame, units changes during SHOW(1).
    rst = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step();
      chk_cycle(k, U1, D1, C1);
      if (k == 9) uni = U2;
    end
    for (int k = 0; k < 10; k++) begin
      step();
      chk_cycle(k, U2, D1, C1);
    end

    // Scenario 3: enable dropped mid SHOW(1) for 5 cycles.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_dark($sformatf("off%0d", i));
    end
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk_cycle(k, U2, D1, C1);
    end

    // Scenario 4: one-cycle reset during SHOW(2), new inputs latched on restart.
    rst = 1'b1;
    uni = U3;
    dec = D3;
    cen = ZERO;
    step();
    chk_dark("midrst");
    rst = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step();
      chk_cycle(k, U3, D3, ZERO);
    end

`ifdef SEG7_SCAN_LZB_EN
    uni = C1;
    dec = ZERO;
    cen = ZERO;
    for (int k = 0; k < 18; k++) begin
      step();
      chk_cycle(k, C1, DARK, DARK);
    end
    cen = U1;
    for (int k = 0; k < 18; k++) begin
      step();
      chk_cycle(k, C1, ZERO, U1);
    end
`else
    uni = C1;
    dec = ZERO;
    cen = ZERO;
    for (int k = 0; k < 18; k++) begin
      step();
      chk_cycle(k, C1, ZERO, ZERO);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
